axi_inval_filter_mp: RTL and testbench

Snooping AXI4 write-path filter that generates L1 cache-line invalidations for every accepted AW burst and forwards all AXI channels unchanged. It sits between a vector/DMA write master and the shared memory interconnect. Invalidations are distributed across `NumPorts` banked L1 invalidation ports, and bursts covering too many lines collapse into a single flush request. An optional mode holds write responses until all pending invalidations have been issued.

---
 rtl/axi_inval_filter_mp.sv | 183 ++++++++++++++++++
 tb/tb_axi_inval_filter_mp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_inval_filter_mp.sv
// axi_inval_filter_mp: forwards AXI unchanged while snooping AW bursts into
// banked L1 line invalidations, or one full flush for oversized bursts.
package axi_inval_filter_mp_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_chan_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        aw_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_inval_filter_mp #(
    parameter int unsigned MaxTxns     = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned NumPorts    = 1,
    parameter int unsigned NumLines    = 256,
    parameter bit          WaitInval   = 1'b0,
    parameter type aw_chan_t = axi_inval_filter_mp_pkg::aw_chan_t,
    parameter type req_t     = axi_inval_filter_mp_pkg::req_t,
    parameter type resp_t    = axi_inval_filter_mp_pkg::resp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  req_t                                slv_req_i,
    output resp_t                               slv_resp_o,
    output req_t                                mst_req_o,
    input  resp_t                               mst_resp_i,
    output logic [NumPorts-1:0][AddrWidth-1:0]  inval_addr_o,
    output logic [NumPorts-1:0]                 inval_valid_o,
    input  logic [NumPorts-1:0]                 inval_ready_i,
    output logic                                flush_valid_o,
    input  logic                                flush_ready_i,
    output logic                                busy_o
);
    localparam int unsigned OffW  = $clog2(L1LineWidth);
    localparam int unsigned PortW = NumPorts > 1 ? $clog2(NumPorts) : 1;
    localparam int unsigned PtrW  = MaxTxns > 1 ? $clog2(MaxTxns) : 1;
    localparam int unsigned CntW  = $clog2(MaxTxns + 1);
    typedef logic [AddrWidth-1:0] addr_t;
    typedef enum logic [1:0] {Idle, Lines, Flush, Drain} state_e;

    state_e          state_q, state_d;
    aw_chan_t        mem_q [MaxTxns];
    aw_chan_t        mem_d [MaxTxns];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    addr_t           cur_q, cur_d;
    aw_chan_t        head;
    addr_t           start, bytes, first, last, n, cur;
    logic [PortW-1:0] sel;
    logic            full, push, pop, empty, over, line_act, line_hs, last_hit;

    assign busy_o = cnt_q != '0 || state_q != Idle;
    assign full   = cnt_q == CntW'(MaxTxns);
    assign push   = rst_ni & en_i & slv_req_i.aw_valid & slv_resp_o.aw_ready;
    // Fall-through: an empty FIFO exposes the AW being pushed this cycle.
    assign empty  = cnt_q == '0 && !push;
    assign head   = cnt_q == '0 ? slv_req_i.aw : mem_q[rd_q];

    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~full;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~full;
        mst_req_o.b_ready   = slv_req_i.b_ready & ~(WaitInval & busy_o);
        slv_resp_o.b_valid  = mst_resp_i.b_valid & ~(WaitInval & busy_o);
    end

    always_comb begin
        bytes = (addr_t'(head.len) + addr_t'(1)) << head.size;
        start = addr_t'(head.addr);
        if (head.burst == 2'b00) bytes = addr_t'(1) << head.size;
        if (head.burst == 2'b10) start = start & ~(bytes - addr_t'(1));
        first = start >> OffW;
        last  = (start + bytes - addr_t'(1)) >> OffW;
        n     = last - first + addr_t'(1);
        over  = n > addr_t'(NumLines);
    end

    always_comb begin
        cur      = state_q == Lines ? cur_q : first << OffW;
        line_act = state_q == Lines || (state_q == Idle && !empty && !over);
        sel      = NumPorts > 1 ? cur[OffW +: PortW] : '0;
        line_hs  = line_act & inval_ready_i[sel];
        last_hit = (cur >> OffW) == last;
        flush_valid_o = state_q == Flush;
        for (int p = 0; p < NumPorts; p++) begin
            inval_valid_o[p] = line_act && sel == PortW'(p);
            inval_addr_o[p]  = inval_valid_o[p] ? cur : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            Idle, Lines: begin
                if (line_act) begin
                    cur_d   = line_hs ? cur + addr_t'(L1LineWidth) : cur;
                    pop     = line_hs & last_hit;
                    state_d = pop ? Idle : Lines;
                end else if (!empty) begin
                    state_d = Flush;
                end
            end
            Flush: begin
                pop     = flush_ready_i;
                state_d = flush_ready_i ? Drain : Flush;
            end
            Drain: begin
                pop     = cnt_q != '0;
                state_d = cnt_q == '0 ? Idle : Drain;
            end
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = slv_req_i.aw;
        wr_d  = push ? (wr_q == PtrW'(MaxTxns - 1) ? '0 : wr_q + PtrW'(1)) : wr_q;
        rd_d  = pop ? (rd_q == PtrW'(MaxTxns - 1) ? '0 : rd_q + PtrW'(1)) : rd_q;
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            cur_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_axi_inval_filter_mp.sv
// tb_axi_inval_filter_mp: vector table plus directed sequences, with an
// expected-invalidation queue checked against every port/flush handshake.
module tb_axi_inval_filter_mp;
    import axi_inval_filter_mp_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic en_i = 1'b1;
    req_t  slv_req, mst_req;
    resp_t slv_resp, mst_resp;
    logic [1:0][63:0] inval_addr;
    logic [1:0] inval_valid, inval_ready;
    logic flush_valid, flush_ready, busy;
    int checks = 0, errors = 0, inval_cnt = 0;

    typedef struct {
        logic        fl;
        logic [63:0] addr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        en;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        fl;
        logic [63:0] first;
        int          n;
    } vec_t;
    vec_t vecs[8];

    always #5 clk_i = ~clk_i;

    axi_inval_filter_mp #(
        .MaxTxns(2), .AddrWidth(64), .L1LineWidth(16), .NumPorts(2),
        .NumLines(8), .WaitInval(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .inval_addr_o(inval_addr), .inval_valid_o(inval_valid), .inval_ready_i(inval_ready),
        .flush_valid_o(flush_valid), .flush_ready_i(flush_ready), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, want);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            exp_t e;
            if (inval_valid != 2'b00) inval_cnt++;
            for (int p = 0; p < 2; p++) begin
                if (inval_valid[p] && inval_ready[p]) begin
                    if (sb.size() == 0) chk("inval_unexpected", 64'(sb.size()), 64'd1);
                    else begin
                        e = sb.pop_front();
                        chk("sb_addr", inval_addr[p], e.addr);
                        chk("sb_port", 64'(p), {63'b0, e.addr[4]});
                    end
                end
            end
            if (flush_valid && flush_ready) begin
                if (sb.size() == 0) chk("flush_unexpected", 64'(sb.size()), 64'd1);
                else begin
                    e = sb.pop_front();
                    chk("sb_flush", {63'b0, flush_valid}, {63'b0, e.fl});
                end
            end
        end
    end

    task automatic drive_aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        slv_req.aw.addr  = a;
        slv_req.aw.len   = l;
        slv_req.aw.size  = s;
        slv_req.aw.burst = b;
        slv_req.aw_valid = 1'b1;
    endtask

    task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        drive_aw(a, l, s, b);
        @(negedge clk_i);
        while (!slv_resp.aw_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("aw_handshake_timeout", 64'(n < 50), 64'd1);
        chk("mst_aw_addr", mst_req.aw.addr, a);
        @(posedge clk_i);
        #1 slv_req.aw_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_i);
        while ((busy || sb.size() != 0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_queue"}, 64'(sb.size()), 64'd0);
        chk({name, "_busy"}, {63'b0, busy}, 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_vec(input vec_t v);
        if (v.en) begin
            if (v.fl) sb.push_back('{1'b1, '1});
            else for (int i = 0; i < v.n; i++) sb.push_back('{1'b0, v.first + 64'(16 * i)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{1'b1, 64'h2000, 8'd0,   3'd3, 2'd1, 1'b0, 64'h2000, 1};
        vecs[1] = '{1'b1, 64'h3018, 8'd3,   3'd3, 2'd2, 1'b0, 64'h3000, 2};
        vecs[2] = '{1'b1, 64'h5038, 8'd7,   3'd2, 2'd0, 1'b0, 64'h5030, 1};
        vecs[3] = '{1'b1, 64'h6000, 8'd7,   3'd4, 2'd1, 1'b0, 64'h6000, 8};
        vecs[4] = '{1'b1, 64'h7008, 8'd7,   3'd4, 2'd1, 1'b1, 64'h0,    0};
        vecs[5] = '{1'b1, 64'h4000, 8'd255, 3'd3, 2'd1, 1'b1, 64'h0,    0};
        vecs[6] = '{1'b0, 64'h8000, 8'd0,   3'd3, 2'd1, 1'b0, 64'h0,    0};
        vecs[7] = '{1'b1, 64'h9ff8, 8'd1,   3'd3, 2'd1, 1'b0, 64'h9ff0, 2};

        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready     = 1'b1;
        mst_resp.aw_ready   = 1'b1;
        mst_resp.w_ready    = 1'b1;
        inval_ready = 2'b11;
        flush_ready = 1'b1;
        #3;
        chk("rst_inval_valid", 64'(inval_valid), 64'd0);
        chk("rst_inval_addr", inval_addr[0] | inval_addr[1], 64'd0);
        chk("rst_flush_valid", {63'b0, flush_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_aw_ready_pass", {63'b0, slv_resp.aw_ready}, 64'd1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Misaligned INCR: one line per port on consecutive cycles.
        sb.push_back('{1'b0, 64'h1000});
        sb.push_back('{1'b0, 64'h1010});
        drive_aw(64'h1008, 8'd3, 3'd2, 2'd1);
        @(negedge clk_i);
        chk("mis_t_valid", 64'(inval_valid), 64'd1);
        chk("mis_t_addr0", inval_addr[0], 64'h1000);
        chk("mis_t_addr1", inval_addr[1], 64'h0);
        @(posedge clk_i);
        #1 slv_req.aw_valid = 1'b0;
        @(negedge clk_i);
        chk("mis_t1_valid", 64'(inval_valid), 64'd2);
        chk("mis_t1_addr1", inval_addr[1], 64'h1010);
        @(negedge clk_i);
        chk("mis_t2_busy", {63'b0, busy}, 64'd0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 8; i++) begin
            en_i = vecs[i].en;
            expect_vec(vecs[i]);
            send(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
            wait_idle($sformatf("vec%0d", i));
        end
        en_i = 1'b1;

        // Flush held off so a second AW queues behind it and is drained.
        flush_ready = 1'b0;
        base = inval_cnt;
        sb.push_back('{1'b1, '1});
        send(64'h4000, 8'd255, 3'd3, 2'd1);
        send(64'h5000, 8'd0, 3'd3, 2'd1);
        @(negedge clk_i);
        chk("flush_valid_held", {63'b0, flush_valid}, 64'd1);
        chk("flush_no_inval", 64'(inval_valid), 64'd0);
        @(posedge clk_i);
        #1 flush_ready = 1'b1;
        wait_idle("flush_drain");
        chk("flush_inval_count", 64'(inval_cnt - base), 64'd0);

        // Port 1 stalled: FIFO fills and B is held while busy.
        inval_ready = 2'b01;
        mst_resp.b_valid = 1'b1;
        repeat (3) sb.push_back('{1'b0, 64'h1010});
        send(64'h1010, 8'd0, 3'd3, 2'd1);
        send(64'h1010, 8'd0, 3'd3, 2'd1);
        drive_aw(64'h1010, 8'd0, 3'd3, 2'd1);
        @(negedge clk_i);
        chk("full_aw_ready", {63'b0, slv_resp.aw_ready}, 64'd0);
        chk("full_mst_aw_valid", {63'b0, mst_req.aw_valid}, 64'd0);
        chk("full_b_valid", {63'b0, slv_resp.b_valid}, 64'd0);
        chk("full_b_ready", {63'b0, mst_req.b_ready}, 64'd0);
        chk("full_busy", {63'b0, busy}, 64'd1);
        @(posedge clk_i);
        #1 inval_ready = 2'b11;
        begin
            int n = 0;
            @(negedge clk_i);
            while (!slv_resp.aw_ready && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            chk("full_release_timeout", 64'(n < 50), 64'd1);
        end
        @(posedge clk_i);
        #1 slv_req.aw_valid = 1'b0;
        wait_idle("full");
        chk("b_valid_after_idle", {63'b0, slv_resp.b_valid}, 64'd1);
        mst_resp.b_valid = 1'b0;

        // Reset asserted while a burst is stalled in Lines.
        inval_ready = 2'b00;
        send(64'h2000, 8'd3, 3'd3, 2'd1);
        @(negedge clk_i);
        chk("mid_burst_valid", 64'(inval_valid), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", 64'(inval_valid), 64'd0);
        chk("async_rst_addr", inval_addr[0], 64'd0);
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        inval_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("post_rst_valid", 64'(inval_valid), 64'd0);
        end
        chk("post_rst_busy", {63'b0, busy}, 64'd0);
        chk("final_queue", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
